// File: rtl/pipe_cu_if.sv
// Decode-side inputs and all pipeline control outputs of the pipelined control unit.
interface pipe_cu_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUCTRL_W  = 4
);
  logic [31:0]           instr_d;
  logic                  zero_e;
  logic                  lt_e;
  logic                  ltu_e;
  logic [2:0]            imm_src_d;
  logic                  illegal_d;
  logic [ALUCTRL_W-1:0]  alu_ctrl_e;
  logic                  alu_src_e;
  logic                  jalr_e;
  logic                  pc_src_e;
  logic                  mem_write_m;
  logic                  reg_write_w;
  logic [1:0]            result_src_w;
  logic [REG_ADDR_W-1:0] rd_w;
  logic [1:0]            forward_a_e;
  logic [1:0]            forward_b_e;
  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_d;
  logic                  flush_e;

  // Datapath / bench side: supplies the instruction and ALU flags.
  modport master (
    output instr_d, zero_e, lt_e, ltu_e,
    input  imm_src_d, illegal_d, alu_ctrl_e, alu_src_e, jalr_e, pc_src_e,
           mem_write_m, reg_write_w, result_src_w, rd_w,
           forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e
  );

  // Control unit side.
  modport slave (
    input  instr_d, zero_e, lt_e, ltu_e,
    output imm_src_d, illegal_d, alu_ctrl_e, alu_src_e, jalr_e, pc_src_e,
           mem_write_m, reg_write_w, result_src_w, rd_w,
           forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e
  );
endinterface

// File: rtl/pipe_cu.sv
// Pipelined RV32I control unit: decode in D, control carried through
// ID/EX, EX/MEM, MEM/WB, branch resolution in E, hazard and forwarding logic.
module pipe_cu #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUCTRL_W  = 4
) (
  input  logic         clk,
  input  logic         rst,
  pipe_cu_if.slave     bus
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(7);
  localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(8);
  localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(9);
  localparam logic [ALUCTRL_W-1:0] ALU_PASSB = ALUCTRL_W'(10);

  // D-stage instruction fields
  logic [6:0]            w_opcode_d;
  logic [2:0]            w_funct3_d;
  logic                  w_f7b5_d;
  logic [REG_ADDR_W-1:0] w_rs1_d, w_rs2_d, w_rd_d;
  logic                  w_unused_bits;

  assign w_opcode_d    = bus.instr_d[6:0];
  assign w_funct3_d    = bus.instr_d[14:12];
  assign w_f7b5_d      = bus.instr_d[30];
  assign w_rs1_d       = bus.instr_d[19:15];
  assign w_rs2_d       = bus.instr_d[24:20];
  assign w_rd_d        = bus.instr_d[11:7];
  assign w_unused_bits = &{bus.instr_d[31], bus.instr_d[29:25]};

  // D-stage decoded controls
  logic                 w_reg_write_d, w_mem_write_d, w_branch_d, w_jump_d;
  logic                 w_jalr_d, w_alu_src_d, w_illegal_d, w_is_r_d;
  logic [1:0]           w_result_src_d;
  logic [2:0]           w_imm_src_d;
  logic [ALUCTRL_W-1:0] w_alu_ctrl_d, w_alu_arith_d;

  // ID/EX
  logic                  r_reg_write_e, r_mem_write_e, r_branch_e, r_jump_e;
  logic                  r_jalr_e, r_alu_src_e;
  logic [1:0]            r_result_src_e;
  logic [ALUCTRL_W-1:0]  r_alu_ctrl_e;
  logic [2:0]            r_funct3_e;
  logic [REG_ADDR_W-1:0] r_rs1_e, r_rs2_e, r_rd_e;

  // EX/MEM and MEM/WB
  logic                  r_reg_write_m, r_mem_write_m;
  logic [1:0]            r_result_src_m;
  logic [REG_ADDR_W-1:0] r_rd_m;
  logic                  r_reg_write_w;
  logic [1:0]            r_result_src_w;
  logic [REG_ADDR_W-1:0] r_rd_w;

  // Hazard / redirect
  logic       w_cond_e, w_pc_src_e, w_lu, w_flush_e;
  logic [1:0] w_fwd_a, w_fwd_b;

  // Arithmetic ALU operation from funct3; sub only for R-type with funct7[5].
  always_comb begin
    w_alu_arith_d = ALU_ADD;
    case (w_funct3_d)
      3'b000:  w_alu_arith_d = (w_is_r_d && w_f7b5_d) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_arith_d = ALU_SLL;
      3'b010:  w_alu_arith_d = ALU_SLT;
      3'b011:  w_alu_arith_d = ALU_SLTU;
      3'b100:  w_alu_arith_d = ALU_XOR;
      3'b101:  w_alu_arith_d = w_f7b5_d ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_arith_d = ALU_OR;
      default: w_alu_arith_d = ALU_AND;
    endcase
  end

  // Main opcode decode; unsupported opcodes decode to a bubble.
  always_comb begin
    w_reg_write_d  = 1'b0;
    w_result_src_d = 2'b00;
    w_mem_write_d  = 1'b0;
    w_branch_d     = 1'b0;
    w_jump_d       = 1'b0;
    w_jalr_d       = 1'b0;
    w_alu_src_d    = 1'b0;
    w_alu_ctrl_d   = ALU_ADD;
    w_imm_src_d    = IMM_I;
    w_illegal_d    = 1'b0;
    w_is_r_d       = 1'b0;
    case (w_opcode_d)
      OP_R: begin
        w_is_r_d      = 1'b1;
        w_reg_write_d = 1'b1;
        w_alu_ctrl_d  = w_alu_arith_d;
      end
      OP_I: begin
        w_reg_write_d = 1'b1;
        w_alu_src_d   = 1'b1;
        w_alu_ctrl_d  = w_alu_arith_d;
      end
      OP_LW: begin
        w_reg_write_d  = 1'b1;
        w_result_src_d = 2'b01;
        w_alu_src_d    = 1'b1;
      end
      OP_SW: begin
        w_mem_write_d = 1'b1;
        w_alu_src_d   = 1'b1;
        w_imm_src_d   = IMM_S;
      end
      OP_BR: begin
        w_branch_d   = 1'b1;
        w_alu_ctrl_d = ALU_SUB;
        w_imm_src_d  = IMM_B;
      end
      OP_JAL: begin
        w_reg_write_d  = 1'b1;
        w_result_src_d = 2'b10;
        w_jump_d       = 1'b1;
        w_imm_src_d    = IMM_J;
      end
      OP_JALR: begin
        w_reg_write_d  = 1'b1;
        w_result_src_d = 2'b10;
        w_jump_d       = 1'b1;
        w_jalr_d       = 1'b1;
        w_alu_src_d    = 1'b1;
      end
      OP_LUI: begin
        w_reg_write_d = 1'b1;
        w_alu_src_d   = 1'b1;
        w_alu_ctrl_d  = ALU_PASSB;
        w_imm_src_d   = IMM_U;
      end
      default: w_illegal_d = 1'b1;
    endcase
  end

  // ID/EX register: captures D every edge, becomes a bubble on flush_e.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_flush_e) begin
      r_reg_write_e  <= 1'b0;
      r_result_src_e <= 2'b00;
      r_mem_write_e  <= 1'b0;
      r_branch_e     <= 1'b0;
      r_jump_e       <= 1'b0;
      r_jalr_e       <= 1'b0;
      r_alu_src_e    <= 1'b0;
      r_alu_ctrl_e   <= '0;
      r_funct3_e     <= 3'b000;
      r_rs1_e        <= '0;
      r_rs2_e        <= '0;
      r_rd_e         <= '0;
    end else begin
      r_reg_write_e  <= w_reg_write_d;
      r_result_src_e <= w_result_src_d;
      r_mem_write_e  <= w_mem_write_d;
      r_branch_e     <= w_branch_d;
      r_jump_e       <= w_jump_d;
      r_jalr_e       <= w_jalr_d;
      r_alu_src_e    <= w_alu_src_d;
      r_alu_ctrl_e   <= w_alu_ctrl_d;
      r_funct3_e     <= w_funct3_d;
      r_rs1_e        <= w_rs1_d;
      r_rs2_e        <= w_rs2_d;
      r_rd_e         <= w_rd_d;
    end
  end

  // EX/MEM and MEM/WB registers: advance unconditionally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write_m  <= 1'b0;
      r_result_src_m <= 2'b00;
      r_mem_write_m  <= 1'b0;
      r_rd_m         <= '0;
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= 2'b00;
      r_rd_w         <= '0;
    end else begin
      r_reg_write_m  <= r_reg_write_e;
      r_result_src_m <= r_result_src_e;
      r_mem_write_m  <= r_mem_write_e;
      r_rd_m         <= r_rd_e;
      r_reg_write_w  <= r_reg_write_m;
      r_result_src_w <= r_result_src_m;
      r_rd_w         <= r_rd_m;
    end
  end

  // Branch condition from funct3 and the ALU flags of the E-stage compare.
  always_comb begin
    w_cond_e = 1'b0;
    case (r_funct3_e)
      3'b000:  w_cond_e = bus.zero_e;
      3'b001:  w_cond_e = ~bus.zero_e;
      3'b100:  w_cond_e = bus.lt_e;
      3'b101:  w_cond_e = ~bus.lt_e;
      3'b110:  w_cond_e = bus.ltu_e;
      3'b111:  w_cond_e = ~bus.ltu_e;
      default: w_cond_e = 1'b0;
    endcase
  end

  assign w_pc_src_e = (r_branch_e & w_cond_e) | r_jump_e;

  // Raw rs fields are compared even for formats without them (conservative).
  assign w_lu = (r_result_src_e == 2'b01) && (r_rd_e != '0) &&
                ((r_rd_e == w_rs1_d) || (r_rd_e == w_rs2_d));
  assign w_flush_e = w_pc_src_e | w_lu;

  // Operand forwarding, M stage wins over W; x0 is never forwarded.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (r_reg_write_m && (r_rd_m != '0) && (r_rd_m == r_rs1_e))      w_fwd_a = 2'b10;
    else if (r_reg_write_w && (r_rd_w != '0) && (r_rd_w == r_rs1_e)) w_fwd_a = 2'b01;
    if (r_reg_write_m && (r_rd_m != '0) && (r_rd_m == r_rs2_e))      w_fwd_b = 2'b10;
    else if (r_reg_write_w && (r_rd_w != '0) && (r_rd_w == r_rs2_e)) w_fwd_b = 2'b01;
  end

  assign bus.imm_src_d    = w_imm_src_d;
  assign bus.illegal_d    = w_illegal_d;
  assign bus.alu_ctrl_e   = r_alu_ctrl_e;
  assign bus.alu_src_e    = r_alu_src_e;
  assign bus.jalr_e       = r_jalr_e;
  assign bus.pc_src_e     = w_pc_src_e;
  assign bus.mem_write_m  = r_mem_write_m;
  assign bus.reg_write_w  = r_reg_write_w;
  assign bus.result_src_w = r_result_src_w;
  assign bus.rd_w         = r_rd_w;
  assign bus.forward_a_e  = w_fwd_a;
  assign bus.forward_b_e  = w_fwd_b;
  // A redirect wins over a load-use stall if both ever assert together.
  assign bus.stall_f      = w_lu & ~w_pc_src_e;
  assign bus.stall_d      = w_lu & ~w_pc_src_e;
  assign bus.flush_d      = w_pc_src_e;
  assign bus.flush_e      = w_flush_e;

endmodule

// File: tb/tb_pipe_cu.sv
// Scoreboard bench for pipe_cu: stimulus queues expected values tagged with
// the cycle (and phase) they must appear in; a monitor compares them.
module tb_pipe_cu;
  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  event ev_mid;

  pipe_cu_if #(.REG_ADDR_W(5), .ALUCTRL_W(4)) bus();
  pipe_cu #(.REG_ADDR_W(5), .ALUCTRL_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam int S_IMM = 0, S_ILL = 1, S_ALU = 2, S_ASRC = 3, S_JALR = 4, S_PC = 5,
                 S_MW = 6, S_RW = 7, S_RSW = 8, S_RDW = 9, S_FA = 10, S_FB = 11,
                 S_STF = 12, S_STD = 13, S_FLD = 14, S_FLE = 15;

  typedef struct {
    int    cyc;
    int    ph;
    int    sig;
    int    val;
    string nm;
  } exp_t;
  exp_t sbq[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_op(input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
    return {12'd0, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_op(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] b_op(input logic [2:0] f3);
    return {7'd0, 5'd0, 5'd0, f3, 5'd0, 7'b1100011};
  endfunction
  function automatic logic [31:0] jal_op(input logic [4:0] rd);
    return {20'd0, rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] actual(input int s);
    case (s)
      S_IMM:  return 32'(bus.imm_src_d);
      S_ILL:  return 32'(bus.illegal_d);
      S_ALU:  return 32'(bus.alu_ctrl_e);
      S_ASRC: return 32'(bus.alu_src_e);
      S_JALR: return 32'(bus.jalr_e);
      S_PC:   return 32'(bus.pc_src_e);
      S_MW:   return 32'(bus.mem_write_m);
      S_RW:   return 32'(bus.reg_write_w);
      S_RSW:  return 32'(bus.result_src_w);
      S_RDW:  return 32'(bus.rd_w);
      S_FA:   return 32'(bus.forward_a_e);
      S_FB:   return 32'(bus.forward_b_e);
      S_STF:  return 32'(bus.stall_f);
      S_STD:  return 32'(bus.stall_d);
      S_FLD:  return 32'(bus.flush_d);
      S_FLE:  return 32'(bus.flush_e);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Queue an expectation dc cycles from now, sampled at the falling edge.
  task automatic ex(input int dc, input int s, input int v, input string nm);
    exp_t e;
    e.cyc = cyc + dc; e.ph = 0; e.sig = s; e.val = v; e.nm = nm;
    sbq.push_back(e);
  endtask

  // Queue an expectation for the next mid-cycle sample point.
  task automatic exm(input int s, input int v, input string nm);
    exp_t e;
    e.cyc = cyc; e.ph = 1; e.sig = s; e.val = v; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic step(input logic [31:0] ins, input logic [2:0] flg);
    @(posedge clk);
    #1;
    bus.instr_d = ins;
    {bus.zero_e, bus.lt_e, bus.ltu_e} = flg;
  endtask

  task automatic pad(input int n);
    for (int i = 0; i < n; i++) step(NOP, 3'b000);
  endtask

  // Monitor: compares due expectations at each falling edge or mid-cycle event.
  initial begin
    logic [31:0] act;
    int ph;
    forever begin
      @(negedge clk or ev_mid);
      ph = clk ? 1 : 0;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc && sbq[i].ph == ph) begin
          act = actual(sbq[i].sig);
          n_tests++;
          if (act !== 32'(sbq[i].val)) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", sbq[i].nm, cyc, act, sbq[i].val);
          end
          sbq.delete(i);
        end else if (ph == 0 && sbq[i].cyc < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s expired at cyc=%0d want=%0d", sbq[i].nm, sbq[i].cyc, sbq[i].val);
          sbq.delete(i);
        end
      end
    end
  end

  initial begin
    int f3s [7] = '{0, 1, 4, 5, 6, 7, 2};
    logic [2:0] etab [7] = '{3'b001, 3'b110, 3'b010, 3'b101, 3'b100, 3'b011, 3'b000};
    logic e;

    rst = 1'b0;
    bus.instr_d = {20'd1, 5'd1, 7'b0110111};
    {bus.zero_e, bus.lt_e, bus.ltu_e} = 3'b000;
    #2 rst = 1'b1;

    // Held in reset: decode follows instr_d, everything else zero
    step({20'd1, 5'd1, 7'b0110111}, 3'b000);
    ex(0, S_IMM, 4, "rst_imm_lui"); ex(0, S_ILL, 0, "rst_ill");
    ex(0, S_ALU, 0, "rst_alu");     ex(0, S_ASRC, 0, "rst_asrc");
    ex(0, S_PC, 0, "rst_pc");       ex(0, S_MW, 0, "rst_mw");
    ex(0, S_RW, 0, "rst_rw");       ex(0, S_RDW, 0, "rst_rdw");
    ex(0, S_FA, 0, "rst_fa");       ex(0, S_STF, 0, "rst_stf");
    ex(0, S_FLE, 0, "rst_fle");
    step(NOP, 3'b000);
    rst = 1'b0;
    pad(3);

    // ALU chain, M forward
    step(r_op(7'h00, 5'd3, 5'd2, 3'b000, 5'd1), 3'b000);
    ex(0, S_ILL, 0, "add_ill"); ex(3, S_RW, 1, "add_rw_w");
    ex(3, S_RDW, 1, "add_rd_w"); ex(3, S_RSW, 0, "add_rs_w");
    step(r_op(7'h20, 5'd5, 5'd1, 3'b000, 5'd4), 3'b000);
    step(NOP, 3'b000);
    ex(0, S_ALU, 1, "sub_alu"); ex(0, S_FA, 2, "chain_fa_m"); ex(0, S_FB, 0, "chain_fb");
    pad(3);

    // ALU chain with a nop between, W forward
    step(r_op(7'h00, 5'd3, 5'd2, 3'b000, 5'd1), 3'b000);
    step(NOP, 3'b000);
    step(r_op(7'h20, 5'd5, 5'd1, 3'b000, 5'd4), 3'b000);
    step(NOP, 3'b000);
    ex(0, S_FA, 1, "chain_fa_w"); ex(0, S_ALU, 1, "sub_alu2");
    pad(3);

    // Load-use
    step(i_op(5'd0, 3'b010, 5'd6, 7'b0000011), 3'b000);
    ex(0, S_IMM, 0, "lw_imm"); ex(2, S_MW, 0, "lw_mw");
    ex(3, S_RSW, 1, "lw_rs_w"); ex(3, S_RDW, 6, "lw_rd_w"); ex(3, S_RW, 1, "lw_rw_w");
    step(r_op(7'h00, 5'd6, 5'd6, 3'b000, 5'd7), 3'b000);
    ex(0, S_STF, 1, "lu_stf"); ex(0, S_STD, 1, "lu_std"); ex(0, S_FLE, 1, "lu_fle");
    ex(0, S_FLD, 0, "lu_fld"); ex(0, S_PC, 0, "lu_pc"); ex(0, S_ASRC, 1, "lw_asrc");
    step(r_op(7'h00, 5'd6, 5'd6, 3'b000, 5'd7), 3'b000);
    ex(0, S_STF, 0, "bub_stf"); ex(0, S_FLE, 0, "bub_fle"); ex(0, S_ASRC, 0, "bub_asrc");
    ex(0, S_ALU, 0, "bub_alu"); ex(0, S_JALR, 0, "bub_jalr"); ex(0, S_PC, 0, "bub_pc");
    step(NOP, 3'b000);
    ex(0, S_FA, 1, "lu_fa_w"); ex(0, S_FB, 1, "lu_fb_w"); ex(0, S_STF, 0, "lu_stf_after");
    pad(3);

    // Branches over three flag patterns (zero, lt, ltu one-hot)
    for (int b = 0; b < 7; b++) begin
      for (int p = 0; p < 3; p++) begin
        step(b_op(3'(f3s[b])), 3'b000);
        if (b == 0 && p == 0) ex(0, S_IMM, 2, "br_imm");
        e = etab[b][p];
        step(NOP, 3'b100 >> p);
        ex(0, S_PC, int'(e), $sformatf("br_f3_%0d_p%0d_pc", f3s[b], p));
        ex(0, S_FLD, int'(e), $sformatf("br_f3_%0d_p%0d_fld", f3s[b], p));
        ex(0, S_FLE, int'(e), $sformatf("br_f3_%0d_p%0d_fle", f3s[b], p));
        if (b == 0 && p == 0) ex(0, S_ALU, 1, "br_alu_sub");
        step(NOP, 3'b100);
        ex(0, S_PC, 0, "br_no_double");
      end
    end
    pad(3);

    // jal
    step(jal_op(5'd1), 3'b000);
    ex(0, S_IMM, 3, "jal_imm"); ex(3, S_RSW, 2, "jal_rs_w");
    ex(3, S_RW, 1, "jal_rw_w"); ex(3, S_RDW, 1, "jal_rd_w");
    step(NOP, 3'b000);
    ex(0, S_PC, 1, "jal_pc"); ex(0, S_JALR, 0, "jal_jalr");
    ex(0, S_FLD, 1, "jal_fld"); ex(0, S_FLE, 1, "jal_fle");
    step(NOP, 3'b000);
    ex(0, S_PC, 0, "jal_bubble_pc");
    pad(2);

    // jalr
    step(i_op(5'd1, 3'b000, 5'd5, 7'b1100111), 3'b000);
    ex(0, S_IMM, 0, "jalr_imm");
    step(NOP, 3'b000);
    ex(0, S_JALR, 1, "jalr_jalr"); ex(0, S_ASRC, 1, "jalr_asrc");
    ex(0, S_PC, 1, "jalr_pc"); ex(0, S_ALU, 0, "jalr_alu");
    pad(3);

    // lw x0 then a user of x0
    step(i_op(5'd2, 3'b010, 5'd0, 7'b0000011), 3'b000);
    step(r_op(7'h00, 5'd0, 5'd0, 3'b000, 5'd3), 3'b000);
    ex(0, S_STF, 0, "x0_stf"); ex(0, S_FLE, 0, "x0_fle");
    step(NOP, 3'b000);
    ex(0, S_FA, 0, "x0_fa"); ex(0, S_FB, 0, "x0_fb");
    pad(3);

    // Illegal opcode 0x7F
    step(32'h0000_02FF, 3'b000);
    ex(0, S_ILL, 1, "ill_flag"); ex(0, S_IMM, 0, "ill_imm");
    ex(1, S_PC, 0, "ill_pc"); ex(1, S_ASRC, 0, "ill_asrc");
    ex(2, S_MW, 0, "ill_mw"); ex(3, S_RW, 0, "ill_rw_w"); ex(3, S_RSW, 0, "ill_rs_w");
    pad(3);

    // Asynchronous reset while a sw is in M
    step(r_op(7'h00, 5'd3, 5'd2, 3'b000, 5'd9), 3'b000);
    step(s_op(5'd9, 5'd1), 3'b000);
    ex(0, S_IMM, 1, "sw_imm");
    step(NOP, 3'b000);
    ex(0, S_FB, 2, "sw_fb_m"); ex(0, S_FLE, 0, "sw_fle");
    step(NOP, 3'b000);
    exm(S_MW, 1, "sw_mw_pre"); exm(S_RW, 1, "add_rw_pre"); exm(S_RDW, 9, "add_rd_pre");
    #1 -> ev_mid;
    #1 rst = 1'b1;
    #1;
    exm(S_MW, 0, "arst_mw"); exm(S_RW, 0, "arst_rw"); exm(S_RDW, 0, "arst_rdw");
    exm(S_RSW, 0, "arst_rsw"); exm(S_FA, 0, "arst_fa"); exm(S_FB, 0, "arst_fb");
    exm(S_PC, 0, "arst_pc"); exm(S_STF, 0, "arst_stf"); exm(S_FLE, 0, "arst_fle");
    exm(S_ALU, 0, "arst_alu"); exm(S_ASRC, 0, "arst_asrc");
    -> ev_mid;
    step({20'd1, 5'd1, 7'b0110111}, 3'b000);
    ex(0, S_IMM, 4, "rst2_imm"); ex(0, S_ALU, 0, "rst2_alu");
    ex(0, S_ASRC, 0, "rst2_asrc"); ex(0, S_RW, 0, "rst2_rw");

    // Release: first instruction reaches E one clock later
    step(r_op(7'h20, 5'd5, 5'd1, 3'b000, 5'd4), 3'b000);
    rst = 1'b0;
    ex(0, S_ALU, 0, "rel_alu0"); ex(1, S_ALU, 1, "rel_alu1");
    pad(5);

    @(negedge clk);
    #1;
    foreach (sbq[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s never checked want=%0d", sbq[i].nm, sbq[i].val);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_cu.md
# pipe_cu

Pipelined successor to the single-cycle control unit for the five-stage RV32I core (F/D/E/M/W). It does the following:
- Decodes the instruction in D.
- Carries control bits through internal ID/EX, EX/MEM and MEM/WB control registers.
- Resolves all six branch conditions in E.
- Produces the load-use stall, control-hazard flush and operand-forwarding selects for the datapath.

The datapath keeps its own F/D and data pipeline registers and obeys this block's stall/flush outputs.

## Interface
- REG_ADDR_W, 5, register-index width (rs1/rs2/rd).
- ALUCTRL_W, 4, ALU control width (minimum 4).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_d  in  32  instruction in Decode.
- zero_e, lt_e, ltu_e  in  1 each  ALU flags in E: result zero, signed A<B, unsigned A<B.
- imm_src_d  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- illegal_d  out  1  opcode in D unsupported.
- alu_ctrl_e  out  ALUCTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 passB.
- alu_src_e  out  1  ALU B = immediate.
- jalr_e  out  1  target = ALU result (else PC+imm).
- pc_src_e  out  1  redirect fetch to target.
- mem_write_m  out  1  store enable.
- reg_write_w  out  1  register-file write.
- result_src_w  out  2  00 ALU, 01 memory, 10 PC+4.
- rd_w  out  REG_ADDR_W  write-back destination.
- forward_a_e, forward_b_e  out  2  00 register file, 10 from M, 01 from W.
- stall_f, stall_d, flush_d, flush_e  out  1 each  hazard controls.

## Operation
- **Supported opcodes**
  - R 0110011, I-ALU 0010011, lw 0000011, sw 0100011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111.
  - Any other opcode: illegal_d=1, all write/branch/jump controls 0 (bubble), imm_src_d=000.
- **ALU decode**
  - funct3 000: sub only when R-type and funct7[5]=1; otherwise add.
  - 101: sra if funct7[5], else srl.
  - 001 sll, 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
  - lw/sw/jalr: add. Branch: sub. lui: passB. jal: add (don't care).
- **D-stage decode**: regwrite, result_src, mem_write, branch, jump, jalr, alu_src, alu_ctrl, funct3, rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7] are captured into ID/EX on every rising edge.
  - ID/EX clears to all-zero when flush_e=1 or rst.
  - EX/MEM latches from ID/EX unconditionally; it holds regwrite, result_src, mem_write, rd.
  - MEM/WB latches from EX/MEM unconditionally; it holds regwrite, result_src, rd.
- **Branch condition in E** (funct3_e):
  - 000 beq zero_e; 001 bne !zero_e.
  - 100 blt lt_e; 101 bge !lt_e.
  - 110 bltu ltu_e; 111 bgeu !ltu_e.
  - 010/011 never taken.
- **Redirect**: pc_src_e = (branch_e & cond) | jump_e (jal and jalr).
- **Load-use hazard**: lu = (result_src_e==01) & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
  - Raw fields are compared regardless of format; this is a deliberately conservative match.
  - Gives stall_f=stall_d=1 and flush_e=1.
- **Control hazard**: pc_src_e=1 gives flush_d=1 and flush_e=1.
  - lu and pc_src_e are mutually exclusive, since E holds either a load or a branch/jump.
  - If both assert anyway, the flush takes precedence: stall_f=stall_d=0.
- **Forwarding (A; B identical using rs2_e)**:
  - 10 if regwrite_m & rd_m!=0 & rd_m==rs1_e.
  - Otherwise 01 if regwrite_w & rd_w!=0 & rd_w==rs1_e.
  - Otherwise 00. M has priority over W.
- **Register x0**: x0 is never forwarded and never triggers a stall.

## Timing
- Decode outputs (imm_src_d, illegal_d) are combinational from instr_d.
- E/M/W control outputs, pc_src_e, forwards and hazard outputs are combinational from current register state plus instr_d and flags. They are valid within the cycle and have no internal latency.
- Control bits of an instruction decoded in cycle n appear at:
  - E outputs in n+1;
  - mem_write_m in n+2;
  - reg_write_w/result_src_w/rd_w in n+3.
- **Load-use**: exactly one bubble is inserted. In the next cycle the load is in M, lu=0, and forward 10 is not used because M data for a load is not ready. The dependency is satisfied by forward 01 one cycle later, when the load is in W.
- **Taken branch/jump**: exactly two instructions are squashed (D and E bubbles). A bubble in E has branch=jump=0, so no double redirect.
- **Reset**: all pipeline control registers are cleared asynchronously, immediately on rst=1 (mid-instruction included).
  - All E/M/W outputs 0, pc_src_e=0, forwards 00, stall/flush 0.
  - Decode outputs still follow instr_d.
- **Release**: first real instruction reaches E one clock after rst deasserts.

## Test plan
- **ALU chain**: add x1,x2,x3 then sub x4,x1,x5 → in sub's E cycle forward_a_e=10, alu_ctrl_e=1. Insert one nop between them → forward_a_e=01.
- **Load-use**: lw x6,0(x0) then add x7,x6,x6 → one cycle with stall_f=stall_d=flush_e=1. Following E cycle has all-zero controls. Add then sees forward_a_e=forward_b_e=01.
- **Branches**: each of beq/bne/blt/bge/bltu/bgeu with flags (zero,lt,ltu) = (1,0,0), (0,1,0), (0,0,1) → pc_src_e matches the condition table. When taken, flush_d=flush_e=1 for that one cycle. funct3 010 → pc_src_e=0.
- **Jumps**:
  - jal x1 → pc_src_e=1, jalr_e=0, result_src_w=10 three cycles after decode.
  - jalr → jalr_e=1, alu_src_e=1.
- **x0 / illegal**:
  - lw x0 followed by a user of x0 → no stall, forwards 00.
  - Opcode 0x7F → illegal_d=1, and reaches W with reg_write_w=0, mem_write_m=0.
- **Reset**: assert rst between clock edges while a sw is in M → mem_write_m falls to 0 immediately, before the next edge. All outputs return to their reset values.
